// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int unsigned MULDIV_XLEN = 32;
    localparam logic [MULDIV_XLEN-1:0] DIV0_QUOT = '1;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic is_div_op(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_div_op(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit_if
// Description : EX-stage handshake bundle between pipeline and muldiv unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface ex_muldiv_unit_if #(
    parameter int unsigned XLEN = muldiv_pkg::MULDIV_XLEN
);
    logic            start_i;
    logic            flush_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      rd_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output start_i, flush_i, funct3_i, op1_i, op2_i, rd_i,
        input  busy_o, done_o, result_o, rd_o
    );

    modport slave (
        input  start_i, flush_i, funct3_i, op1_i, op2_i, rd_i,
        output busy_o, done_o, result_o, rd_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_operand_prep.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_operand_prep
// Description : Operand sign/magnitude split, special-case detection and the
//               final sign correction of product, quotient and remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_operand_prep
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = MULDIV_XLEN
) (
    input  muldiv_op_e        i_op,
    input  logic [XLEN-1:0]   i_op1,
    input  logic [XLEN-1:0]   i_op2,
    output logic [XLEN-1:0]   o_abs_a,
    output logic [XLEN-1:0]   o_abs_b,
    output logic              o_neg_res,
    output logic              o_neg_rem,
    output logic              o_special,
    output logic [XLEN-1:0]   o_special_res,
    input  muldiv_op_e        i_fix_op,
    input  logic              i_fix_neg_res,
    input  logic              i_fix_neg_rem,
    input  logic [2*XLEN-1:0] i_fix_acc,
    output logic [XLEN-1:0]   o_fix_res
);

    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_div0;
    logic            w_ovf;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0] w_quot;
    logic [XLEN-1:0] w_rem;

    // MUL's low half is sign-agnostic, so treating it as signed keeps one path
    assign w_a_signed = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                        is_signed_div_op(i_op);
    assign w_b_signed = (i_op == OP_MUL) || (i_op == OP_MULH) || is_signed_div_op(i_op);
    assign w_a_neg    = w_a_signed & i_op1[XLEN-1];
    assign w_b_neg    = w_b_signed & i_op2[XLEN-1];

    assign o_abs_a    = w_a_neg ? -i_op1 : i_op1;
    assign o_abs_b    = w_b_neg ? -i_op2 : i_op2;
    assign o_neg_res  = w_a_neg ^ w_b_neg;
    assign o_neg_rem  = w_a_neg;

    assign w_div0     = is_div_op(i_op) && (i_op2 == '0);
    assign w_ovf      = is_signed_div_op(i_op) && (i_op1 == c_int_min) && (i_op2 == '1);
    assign o_special  = w_div0 | w_ovf;

    always_comb begin
        o_special_res = '0;
        if (w_div0) begin
            if ((i_op == OP_DIV) || (i_op == OP_DIVU)) begin
                o_special_res = XLEN'(DIV0_QUOT);
            end else begin
                o_special_res = i_op1;
            end
        end else if (w_ovf && (i_op == OP_DIV)) begin
            o_special_res = c_int_min;
        end
    end

    // Divide packs {remainder, quotient} into the same accumulator as the product
    assign w_prod_fix = i_fix_neg_res ? -i_fix_acc : i_fix_acc;
    assign w_quot     = i_fix_acc[XLEN-1:0];
    assign w_rem      = i_fix_acc[2*XLEN-1:XLEN];

    always_comb begin
        o_fix_res = '0;
        case (i_fix_op)
            OP_MUL:                       o_fix_res = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: o_fix_res = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              o_fix_res = i_fix_neg_res ? -w_quot : w_quot;
            OP_REM, OP_REMU:              o_fix_res = i_fix_neg_rem ? -w_rem : w_rem;
            default:                      o_fix_res = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : Iterative RV32M multiply/divide unit in EX. Optional macro
//               MULDIV_FAST_MUL_EN selects a single-cycle multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = MULDIV_XLEN,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    ex_muldiv_unit_if.slave bus
);

    muldiv_state_e     r_state;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic [CNT_W-1:0]  r_cnt;
    muldiv_op_e        r_op;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic [4:0]        r_rd;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_rd_out;

    muldiv_op_e        w_op;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_neg_res;
    logic              w_neg_rem;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_sub;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_acc_next;
    muldiv_op_e        w_fix_op;
    logic              w_fix_neg_res;
    logic              w_fix_neg_rem;
    logic [2*XLEN-1:0] w_fix_acc;
    logic [XLEN-1:0]   w_fix_res;

    assign w_op = muldiv_op_e'(bus.funct3_i);

    muldiv_operand_prep #(
        .XLEN(XLEN)
    ) u_prep (
        .i_op          (w_op),
        .i_op1         (bus.op1_i),
        .i_op2         (bus.op2_i),
        .o_abs_a       (w_abs_a),
        .o_abs_b       (w_abs_b),
        .o_neg_res     (w_neg_res),
        .o_neg_rem     (w_neg_rem),
        .o_special     (w_special),
        .o_special_res (w_special_res),
        .i_fix_op      (w_fix_op),
        .i_fix_neg_res (w_fix_neg_res),
        .i_fix_neg_rem (w_fix_neg_rem),
        .i_fix_acc     (w_fix_acc),
        .o_fix_res     (w_fix_res)
    );

    // Divide step: restoring subtract of divisor from {rem, next dividend bit}
    assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_sub   = w_div_shift - {1'b0, r_opb};
    // Multiply step: conditional add into the upper half, then shift right
    assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);

    always_comb begin
        w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
        if (is_div_op(r_op)) begin
            if (!w_div_sub[XLEN]) begin
                w_acc_next = {w_div_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_acc_next = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            end
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;

    assign w_fast_prod = {{XLEN{1'b0}}, w_abs_a} * {{XLEN{1'b0}}, w_abs_b};

    // In IDLE the sign fix works on the live operands for the one-cycle product
    always_comb begin
        w_fix_op      = r_op;
        w_fix_neg_res = r_neg_res;
        w_fix_neg_rem = r_neg_rem;
        w_fix_acc     = w_acc_next;
        if (r_state == ST_IDLE) begin
            w_fix_op      = w_op;
            w_fix_neg_res = w_neg_res;
            w_fix_neg_rem = w_neg_rem;
            w_fix_acc     = w_fast_prod;
        end
    end
`else
    assign w_fix_op      = r_op;
    assign w_fix_neg_res = r_neg_res;
    assign w_fix_neg_rem = r_neg_rem;
    assign w_fix_acc     = w_acc_next;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_opb     <= '0;
            r_cnt     <= '0;
            r_op      <= OP_MUL;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_rd      <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_rd_out  <= '0;
        end else if (bus.flush_i) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_op      <= w_op;
                        r_neg_res <= w_neg_res;
                        r_neg_rem <= w_neg_rem;
                        r_rd      <= bus.rd_i;
                        r_opb     <= w_abs_b;
                        if (w_special) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_special_res;
                            r_rd_out <= bus.rd_i;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!is_div_op(w_op)) begin
                            r_state  <= ST_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_fix_res;
                            r_rd_out <= bus.rd_i;
                        end
`endif
                        else begin
                            r_state <= ST_CALC;
                            r_cnt   <= CNT_W'(XLEN);
                            r_acc   <= {{XLEN{1'b0}}, w_abs_a};
                        end
                    end
                end
                ST_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state  <= ST_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_fix_res;
                        r_rd_out <= r_rd;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Busy drops in DONE so the pipeline advances in the result cycle
    assign bus.busy_o   = ((r_state == ST_IDLE) & bus.start_i & ~bus.flush_i) |
                          (r_state == ST_CALC);
    assign bus.done_o   = r_done;
    assign bus.result_o = r_result;
    assign bus.rd_o     = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Self-checking bench for ex_muldiv_unit (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[18];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_muldiv_unit_if #(.XLEN(32)) bus();

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, p;
        logic signed [31:0] s32a, s32b;
        logic [63:0] up;
        logic [31:0] r;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ub   = {32'd0, b};
        s32a = a;
        s32b = b;
        up   = {32'd0, a} * {32'd0, b};
        r    = '0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: r = up[63:32];
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = s32a / s32b;
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = s32a % s32b;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2]) begin
            if (b == 0) return 1;
            if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return 33;
`endif
    endfunction

    // Scoreboard consumer: every done_o pulse must match the oldest pending op
    always @(posedge clk) begin
        #1;
        if (bus.done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 32'(bus.done_o), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", bus.result_o, mon_e.res);
                check("rd_out", 32'(bus.rd_o), 32'(mon_e.rd));
                check("done_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.funct3_i = f;
        bus.op1_i    = a;
        bus.op2_i    = b;
        bus.rd_i     = rd;
        bus.start_i  = 1'b1;
        bus.flush_i  = 1'b0;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp);
        sb_t e;
        int  lat;
        int  busy_cnt;
        bit  seen;
        lat = exp_lat(f, a, b);
        @(negedge clk);
        drive(f, a, b, rd);
        e.res = exp;
        e.rd  = rd;
        e.due = cyc + lat;
        sb_q.push_back(e);
        busy_cnt = 0;
        seen = 1'b0;
        #1;
        if (bus.busy_o) busy_cnt++;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.busy_o) busy_cnt++;
            if (sb_q.size() == 0) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (!seen) sb_q.delete();
        check("busy_cycles", 32'(busy_cnt), 32'(lat));
        bus.start_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000};
        vecs[3]  = '{3'd5, 32'd100,        32'd7,         5'd8,  32'd14};
        vecs[4]  = '{3'd7, 32'd100,        32'd7,         5'd9,  32'd2};
        vecs[5]  = '{3'd4, 32'hFFFF_FF9C,  32'd7,         5'd10, 32'hFFFF_FFF2};
        vecs[6]  = '{3'd6, 32'hFFFF_FF9C,  32'd7,         5'd11, 32'hFFFF_FFFE};
        vecs[7]  = '{3'd4, 32'd1234,       32'd0,         5'd12, 32'hFFFF_FFFF};
        vecs[8]  = '{3'd6, 32'd5,          32'd0,         5'd13, 32'd5};
        vecs[9]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000};
        vecs[10] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'd0};
        vecs[11] = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFF};
        vecs[12] = '{3'd5, 32'd5,          32'd0,         5'd17, 32'hFFFF_FFFF};
        vecs[13] = '{3'd7, 32'd5,          32'd0,         5'd18, 32'd5};
        vecs[14] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd19, 32'h4000_0000};
        vecs[15] = '{3'd0, 32'h1234_5678,  32'h0000_0010, 5'd20, 32'h2345_6780};
        vecs[16] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 5'd21, 32'hFFFF_FFFD};
        vecs[17] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 5'd22, 32'd1};

        bus.start_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.funct3_i = '0;
        bus.op1_i    = '0;
        bus.op2_i    = '0;
        bus.rd_i     = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        check("rst_rd", 32'(bus.rd_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);

        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);
        end

        repeat (3) @(negedge clk);
        check("result_hold", bus.result_o, vecs[17].exp);
        check("done_idle", 32'(bus.done_o), 32'd0);

        for (int i = 0; i < 10; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            issue(rf, ra, rb, 5'(i + 1), ref_model(rf, ra, rb));
        end

        // Flush at CALC cycle 10, then restart immediately
        @(negedge clk);
        drive(3'd5, 32'd1000, 32'd3, 5'd30);
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        check("flush_busy", 32'(bus.busy_o), 32'd0);
        check("flush_done", 32'(bus.done_o), 32'd0);
        issue(3'd5, 32'd1000, 32'd3, 5'd29, 32'd333);

        // Flush and start together: flush wins, even for a one-cycle special op
        @(negedge clk);
        drive(3'd4, 32'd50, 32'd0, 5'd3);
        bus.flush_i = 1'b1;
        #1;
        check("flush_start_busy", 32'(bus.busy_o), 32'd0);
        @(posedge clk);
        #1;
        check("flush_start_done", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        repeat (40) @(negedge clk);

        // Reset mid-calculation clears outputs
        @(negedge clk);
        drive(3'd5, 32'h0000_FFFF, 32'd3, 5'd4);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_done", 32'(bus.done_o), 32'd0);
        check("midrst_result", bus.result_o, 32'd0);
        check("midrst_rd", 32'(bus.rd_o), 32'd0);
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        issue(3'd5, 32'h0000_FFFF, 32'd3, 5'd4, 32'h0000_5555);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
